march_controller: RTL and testbench
===================================

MARCH_CONTROLLER -- requirements
Module: march_controller

Interface
REQ-001 Parameter a_width, default 4: address width; N = 2^a_width locations under test.
REQ-002 Parameter d_width, default 8: memory data width.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 start  input  1  begin a test run; sampled only in IDLE.
REQ-006 address  input  a_width  current address from the downstream address generator.
REQ-007 addr_reset  output  1  address generator load-to-zero request.
REQ-008 addr_preset  output  1  address generator load-to-all-ones request.
REQ-009 addr_en  output  1  address generator step enable.
REQ-010 addr_up_down  output  1  step direction; 1 = increment, 0 = decrement.
REQ-011 mem_we  output  1  memory write strobe.
REQ-012 mem_re  output  1  memory read strobe.
REQ-013 mem_wdata  output  d_width  write data.
REQ-014 mem_rdata  input  d_width  read data, valid in the cycle after mem_re.
REQ-015 busy  output  1  test run in progress.
REQ-016 done  output  1  run complete; held until next accepted start or reset.
REQ-017 fail  output  1  sticky mismatch flag for the current run.
REQ-018 fail_addr  output  a_width  address of first mismatch.
REQ-019 fail_element  output  3  March element index (0-5) of first mismatch.

Function
REQ-020 The block SHALL run March C-: M0 up(w0); M1 up(r0,w1); M2 up(r1,w0); M3 down(r0,w1); M4 down(r1,w0); M5 up(r0).
REQ-021 Data "0" SHALL be all-zeros and data "1" all-ones, each d_width bits.
REQ-022 States SHALL be IDLE, SETUP, OP0, OP1, DRAIN, DONE.
REQ-023 IDLE or DONE with start=1 SHALL go to SETUP for M0 and clear fail, fail_addr, fail_element, and done.
REQ-024 SETUP SHALL last one cycle.
REQ-025 In SETUP, an up element SHALL assert addr_reset and a down element SHALL assert addr_preset, with addr_en=0 and no memory access.
REQ-026 OP0 SHALL perform the first operation of the element at the current address.
REQ-027 OP1 SHALL perform the second operation; single-operation elements (M0, M5) SHALL skip OP1.
REQ-028 addr_en SHALL be asserted in the last operation cycle of each address, except at the element's final address.
REQ-029 addr_up_down SHALL equal the element direction in every cycle of the element.
REQ-030 The final address SHALL be all-ones for up elements and zero for down elements; its last operation SHALL go to SETUP of the next element, or to DRAIN after M5.
REQ-031 For each read, the expected value, element index, and address SHALL be registered with mem_re.
REQ-032 Each read SHALL be compared against mem_rdata in the following cycle.
REQ-033 On the first mismatch, fail SHALL be set and fail_addr/fail_element captured; later mismatches SHALL not change them.
REQ-034 The run SHALL continue to completion after a mismatch.
REQ-035 DRAIN SHALL last one cycle and complete the final M5 compare, then go to DONE.
REQ-036 busy SHALL be 1 in SETUP, OP0, OP1, and DRAIN.
REQ-037 done SHALL be 1 only in DONE.
REQ-038 busy SHALL be high for exactly 10N+7 cycles (167 for a_width=4).
REQ-039 start while busy SHALL be ignored.
REQ-040 mem_we and mem_re SHALL never be asserted in the same cycle.
REQ-041 mem_wdata SHALL be zero when mem_we=0.

Reset
REQ-042 reset=1 at a rising edge SHALL force IDLE and drive every output to 0, overriding start.
REQ-043 Reset mid-run SHALL abort the run with no residual compare: the pending read is discarded and fail stays 0.
REQ-044 After reset, addr_reset, addr_preset, addr_en, mem_we, and mem_re SHALL be 0 from the next cycle until a new start.

Verification
REQ-045 Fault-free memory model, a_width=4, one start pulse -> busy 167 cycles, 80 writes, 80 reads, then done=1, fail=0.
REQ-046 Bit 0 stuck-at-1 at address 5 -> fail=1, fail_element=1, fail_addr=5; run still completes, busy 167 cycles.
REQ-047 Bit 3 stuck-at-0 at address 9 -> fail=1, fail_element=2, fail_addr=9.
REQ-048 reset pulsed at busy cycle 50 -> next cycle all outputs 0; a later start gives a full 167-cycle run with fail=0.
REQ-049 start repeated at busy cycles 10 and 100 -> ignored, total still 167; start in DONE -> done cleared, fail cleared, new run.
REQ-050 Address-control trace check -> addr_reset before M0/M1/M2/M5, addr_preset before M3/M4, N-1 addr_en per element, addr_up_down=0 only in M3/M4.

Source files
------------

// File: rtl/march_controller_if.sv
// March C- controller bus bundle.
// Groups the run handshake (start/busy/done), the fault report (fail, fail_addr,
// fail_element), the downstream address-generator controls and the memory
// strobes/data. clk and reset stay plain ports on the modules.
//   master : controller side (drives address controls, memory strobes, status)
//   slave  : environment side (drives start, address, mem_rdata)
interface march_controller_if #(
  parameter int unsigned a_width = 4,
  parameter int unsigned d_width = 8
) ();
  logic               start;
  logic [a_width-1:0] address;
  logic               addr_reset;
  logic               addr_preset;
  logic               addr_en;
  logic               addr_up_down;
  logic               mem_we;
  logic               mem_re;
  logic [d_width-1:0] mem_wdata;
  logic [d_width-1:0] mem_rdata;
  logic               busy;
  logic               done;
  logic               fail;
  logic [a_width-1:0] fail_addr;
  logic [2:0]         fail_element;

  modport master (
    input  start, address, mem_rdata,
    output addr_reset, addr_preset, addr_en, addr_up_down,
    output mem_we, mem_re, mem_wdata,
    output busy, done, fail, fail_addr, fail_element
  );

  modport slave (
    output start, address, mem_rdata,
    input  addr_reset, addr_preset, addr_en, addr_up_down,
    input  mem_we, mem_re, mem_wdata,
    input  busy, done, fail, fail_addr, fail_element
  );
endinterface

// File: rtl/march_controller.sv
// March C- memory test controller.
// Runs M0 up(w0); M1 up(r0,w1); M2 up(r1,w0); M3 down(r0,w1); M4 down(r1,w0);
// M5 up(r0) over 2^a_width locations, steering an external address generator.
// Ports:
//   clk    : single clock, rising edge
//   reset  : synchronous active-high reset
//   bus    : march_controller_if.master (start/busy/done, fail report,
//            address-generator controls, memory strobes and data)
// Read data returns in the cycle after mem_re; the expected value, element and
// address of each read are registered with mem_re and compared in that cycle.
module march_controller #(
  parameter int unsigned a_width = 4,
  parameter int unsigned d_width = 8
) (
  input logic                clk,
  input logic                reset,
  march_controller_if.master bus
);

  typedef enum logic [2:0] {StIdle, StSetup, StOp0, StOp1, StDrain, StDone} state_e;

  state_e             state_q, state_d;
  logic [2:0]         elem_q, elem_d;
  logic               fail_q, fail_d;
  logic [a_width-1:0] fail_addr_q, fail_addr_d;
  logic [2:0]         fail_elem_q, fail_elem_d;
  logic               rd_pend_q, rd_pend_d;
  logic [d_width-1:0] rd_exp_q, rd_exp_d;
  logic [a_width-1:0] rd_addr_q, rd_addr_d;
  logic [2:0]         rd_elem_q, rd_elem_d;

  logic               elem_up, elem_two_op, op0_read_ones, op1_write_ones;
  logic               last_addr, start_ok, mismatch, addr_last_op;
  logic               addr_reset, addr_preset, addr_en, addr_up_down;
  logic               mem_we, mem_re, busy, done;
  logic [d_width-1:0] mem_wdata;

  // Element decode: M3/M4 run downward, M1..M4 have two operations.
  assign elem_up        = (elem_q != 3'd3) && (elem_q != 3'd4);
  assign elem_two_op    = (elem_q >= 3'd1) && (elem_q <= 3'd4);
  assign op0_read_ones  = (elem_q == 3'd2) || (elem_q == 3'd4);
  assign op1_write_ones = (elem_q == 3'd1) || (elem_q == 3'd3);
  assign last_addr      = elem_up ? (&bus.address) : (~|bus.address);

  assign start_ok = bus.start && ((state_q == StIdle) || (state_q == StDone));
  assign mismatch = rd_pend_q && (bus.mem_rdata != rd_exp_q);

  always_comb begin
    state_d      = state_q;
    elem_d       = elem_q;
    addr_reset   = 1'b0;
    addr_preset  = 1'b0;
    addr_en      = 1'b0;
    addr_up_down = 1'b0;
    mem_we       = 1'b0;
    mem_re       = 1'b0;
    mem_wdata    = '0;
    busy         = 1'b0;
    done         = 1'b0;
    addr_last_op = 1'b0;

    unique case (state_q)
      StIdle, StDone: begin
        done = (state_q == StDone);
        if (bus.start) begin
          state_d = StSetup;
          elem_d  = 3'd0;
        end
      end
      StSetup: begin
        busy         = 1'b1;
        addr_reset   = elem_up;
        addr_preset  = !elem_up;
        addr_up_down = elem_up;
        state_d      = StOp0;
      end
      StOp0: begin
        busy         = 1'b1;
        addr_up_down = elem_up;
        if (elem_q == 3'd0) begin
          mem_we = 1'b1;
        end else begin
          mem_re = 1'b1;
        end
        if (elem_two_op) begin
          state_d = StOp1;
        end else begin
          addr_last_op = 1'b1;
        end
      end
      StOp1: begin
        busy         = 1'b1;
        addr_up_down = elem_up;
        mem_we       = 1'b1;
        mem_wdata    = {d_width{op1_write_ones}};
        addr_last_op = 1'b1;
      end
      StDrain: begin
        busy    = 1'b1;
        state_d = StDone;
      end
      default: state_d = StIdle;
    endcase

    // Last operation at an address: step, or leave the element at its end.
    if (addr_last_op) begin
      if (last_addr) begin
        if (elem_q == 3'd5) begin
          state_d = StDrain;
        end else begin
          state_d = StSetup;
          elem_d  = elem_q + 3'd1;
        end
      end else begin
        addr_en = 1'b1;
        state_d = StOp0;
      end
    end
  end

  always_comb begin
    fail_d      = fail_q;
    fail_addr_d = fail_addr_q;
    fail_elem_d = fail_elem_q;
    rd_pend_d   = mem_re;
    rd_exp_d    = {d_width{op0_read_ones}};
    rd_addr_d   = bus.address;
    rd_elem_d   = elem_q;
    if (start_ok) begin
      fail_d      = 1'b0;
      fail_addr_d = '0;
      fail_elem_d = '0;
    end else if (mismatch && !fail_q) begin
      // Only the first mismatch of a run is recorded.
      fail_d      = 1'b1;
      fail_addr_d = rd_addr_q;
      fail_elem_d = rd_elem_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      elem_q      <= '0;
      fail_q      <= 1'b0;
      fail_addr_q <= '0;
      fail_elem_q <= '0;
      rd_pend_q   <= 1'b0;
      rd_exp_q    <= '0;
      rd_addr_q   <= '0;
      rd_elem_q   <= '0;
    end else begin
      state_q     <= state_d;
      elem_q      <= elem_d;
      fail_q      <= fail_d;
      fail_addr_q <= fail_addr_d;
      fail_elem_q <= fail_elem_d;
      rd_pend_q   <= rd_pend_d;
      rd_exp_q    <= rd_exp_d;
      rd_addr_q   <= rd_addr_d;
      rd_elem_q   <= rd_elem_d;
    end
  end

  assign bus.addr_reset   = addr_reset;
  assign bus.addr_preset  = addr_preset;
  assign bus.addr_en      = addr_en;
  assign bus.addr_up_down = addr_up_down;
  assign bus.mem_we       = mem_we;
  assign bus.mem_re       = mem_re;
  assign bus.mem_wdata    = mem_wdata;
  assign bus.busy         = busy;
  assign bus.done         = done;
  assign bus.fail         = fail_q;
  assign bus.fail_addr    = fail_addr_q;
  assign bus.fail_element = fail_elem_q;

endmodule

// File: tb/tb_march_controller.sv
// Bench for march_controller: models the address generator and a memory with an
// optional stuck-at fault, builds the expected per-cycle output trace of a whole
// March C- run from the element list, and compares the DUT against it.
module tb_march_controller;

  localparam int unsigned AW = 4;
  localparam int unsigned DW = 8;
  localparam int          N  = 1 << AW;

  localparam int W0 = 1;
  localparam int W1 = 2;
  localparam int R0 = 3;
  localparam int R1 = 4;

  typedef struct packed {
    logic          busy;
    logic          done;
    logic          ar;
    logic          ap;
    logic          en;
    logic          ud;
    logic          we;
    logic          re;
    logic [DW-1:0] wd;
    logic          fail;
    logic [AW-1:0] faddr;
    logic [2:0]    felem;
  } cyc_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  march_controller_if #(.a_width(AW), .d_width(DW)) bus ();

  march_controller #(.a_width(AW), .d_width(DW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Fault description shared by the memory and the model.
  int            f_addr = -1;
  logic [DW-1:0] f_sa1  = '0;
  logic [DW-1:0] f_sa0  = '0;

  function automatic logic [DW-1:0] faulty(input logic [DW-1:0] v, input int a);
    if (a == f_addr) return (v | f_sa1) & ~f_sa0;
    return v;
  endfunction

  // Address generator and memory.
  logic [AW-1:0] agen = '0;
  logic [DW-1:0] mem [N];
  always @(posedge clk) begin
    if (bus.addr_reset) agen <= '0;
    else if (bus.addr_preset) agen <= '1;
    else if (bus.addr_en) agen <= bus.addr_up_down ? agen + 1'b1 : agen - 1'b1;
    if (bus.mem_we) mem[agen] <= bus.mem_wdata;
    if (bus.mem_re) bus.mem_rdata <= faulty(mem[agen], int'(agen));
  end
  assign bus.address = agen;

  bit cnt_clr = 1'b0;
  int busy_cnt, wr_cnt, rd_cnt, en_cnt, ar_cnt, ap_cnt;
  always @(posedge clk) begin
    if (cnt_clr) begin
      busy_cnt <= 0; wr_cnt <= 0; rd_cnt <= 0; en_cnt <= 0; ar_cnt <= 0; ap_cnt <= 0;
    end else begin
      busy_cnt <= busy_cnt + (bus.busy ? 1 : 0);
      wr_cnt   <= wr_cnt + (bus.mem_we ? 1 : 0);
      rd_cnt   <= rd_cnt + (bus.mem_re ? 1 : 0);
      en_cnt   <= en_cnt + (bus.addr_en ? 1 : 0);
      ar_cnt   <= ar_cnt + (bus.addr_reset ? 1 : 0);
      ap_cnt   <= ap_cnt + (bus.addr_preset ? 1 : 0);
    end
  end

  int   n_tests = 0;
  int   n_fail  = 0;
  cyc_t trace[$];

  function automatic int op_of(input int e, input int k);
    if (k == 0) return (e == 0) ? W0 : ((e == 2 || e == 4) ? R1 : R0);
    if (e == 1 || e == 3) return W1;
    if (e == 2 || e == 4) return W0;
    return 0;
  endfunction

  function automatic bit up_of(input int e);
    return !(e == 3 || e == 4);
  endfunction

  // Expected trace: SETUP, per-address operations, DRAIN, then two DONE cycles.
  function automatic void build_trace();
    logic [DW-1:0] mm [N];
    logic [DW-1:0] ex;
    cyc_t          c;
    int            rfirst, fa, fe, nops, a, o;
    bit            up;
    trace.delete();
    rfirst = -1; fa = 0; fe = 0;
    for (int e = 0; e < 6; e++) begin
      up   = up_of(e);
      nops = (op_of(e, 1) == 0) ? 1 : 2;
      c = '0; c.busy = 1'b1; c.ar = up; c.ap = !up; c.ud = up;
      trace.push_back(c);
      for (int i = 0; i < N; i++) begin
        a = up ? i : N - 1 - i;
        for (int k = 0; k < nops; k++) begin
          o = op_of(e, k);
          c = '0; c.busy = 1'b1; c.ud = up;
          c.en = (k == nops - 1) && (i != N - 1);
          if (o == W0 || o == W1) begin
            c.we = 1'b1;
            c.wd = (o == W1) ? {DW{1'b1}} : '0;
            mm[a] = c.wd;
          end else begin
            c.re = 1'b1;
            ex = (o == R1) ? {DW{1'b1}} : '0;
            if (faulty(mm[a], a) != ex && rfirst < 0) begin
              rfirst = trace.size(); fa = a; fe = e;
            end
          end
          trace.push_back(c);
        end
      end
    end
    c = '0; c.busy = 1'b1; trace.push_back(c);
    c = '0; c.done = 1'b1; trace.push_back(c); trace.push_back(c);
    // Compare happens the cycle after the read; the flag shows one cycle later.
    if (rfirst >= 0) begin
      for (int j = rfirst + 2; j < trace.size(); j++) begin
        c = trace[j]; c.fail = 1'b1; c.faddr = AW'(fa); c.felem = 3'(fe); trace[j] = c;
      end
    end
  endfunction

  function automatic cyc_t sample();
    cyc_t c;
    c.busy = bus.busy; c.done = bus.done; c.ar = bus.addr_reset; c.ap = bus.addr_preset;
    c.en = bus.addr_en; c.ud = bus.addr_up_down; c.we = bus.mem_we; c.re = bus.mem_re;
    c.wd = bus.mem_wdata; c.fail = bus.fail; c.faddr = bus.fail_addr;
    c.felem = bus.fail_element;
    return c;
  endfunction

  task automatic check(input string name, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic check_zero(input string name);
    cyc_t act;
    act = sample();
    n_tests++;
    if (act != '0) begin
      n_fail++;
      $display("FAIL %s: got %h expected all zero", name, act);
    end
  endtask

  task automatic check_trace(input int ncyc);
    cyc_t act;
    for (int i = 0; i < ncyc; i++) begin
      @(negedge clk);
      act = sample();
      n_tests++;
      if (act !== trace[i]) begin
        n_fail++;
        $display("FAIL trace cycle %0d: got %h expected %h", i, act, trace[i]);
      end
    end
  endtask

  task automatic start_run();
    @(posedge clk); #1; cnt_clr = 1'b1;
    @(posedge clk); #1; cnt_clr = 1'b0; bus.start = 1'b1;
    @(posedge clk); #1; bus.start = 1'b0;
  endtask

  task automatic full_run(input bit extra);
    build_trace();
    start_run();
    fork
      check_trace(trace.size());
      if (extra) begin
        repeat (10) @(posedge clk);
        #1 bus.start = 1'b1;
        @(posedge clk); #1 bus.start = 1'b0;
        repeat (89) @(posedge clk);
        #1 bus.start = 1'b1;
        @(posedge clk); #1 bus.start = 1'b0;
      end
    join
    check("busy cycles", busy_cnt, 167);
    check("writes", wr_cnt, 80);
    check("reads", rd_cnt, 80);
    check("addr_en count", en_cnt, 90);
    check("addr_reset count", ar_cnt, 4);
    check("addr_preset count", ap_cnt, 2);
    check("done", int'(bus.done), 1);
  endtask

  task automatic abort_run(input int k);
    build_trace();
    start_run();
    fork
      check_trace(k + 1);
      begin
        repeat (k) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk); #1 reset = 1'b0;
      end
    join
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check_zero("post-abort idle");
    end
  endtask

  task automatic set_fault(input int a, input logic [DW-1:0] s1, input logic [DW-1:0] s0);
    f_addr = a; f_sa1 = s1; f_sa0 = s0;
  endtask

  initial begin
    bus.start = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_zero("reset state");
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    check_zero("idle after reset");

    set_fault(-1, '0, '0);
    full_run(1'b0);
    check("clean fail", int'(bus.fail), 0);

    // Bit 0 stuck-at-1 at address 5; started from DONE.
    set_fault(5, 8'h01, 8'h00);
    full_run(1'b0);
    check("sa1 fail", int'(bus.fail), 1);
    check("sa1 fail_element", int'(bus.fail_element), 1);
    check("sa1 fail_addr", int'(bus.fail_addr), 5);

    // Bit 3 stuck-at-0 at address 9; fail from previous run must clear.
    set_fault(9, 8'h00, 8'h08);
    full_run(1'b0);
    check("sa0 fail", int'(bus.fail), 1);
    check("sa0 fail_element", int'(bus.fail_element), 2);
    check("sa0 fail_addr", int'(bus.fail_addr), 9);

    // Starts while busy are ignored.
    set_fault(-1, '0, '0);
    full_run(1'b1);
    check("ignored starts fail", int'(bus.fail), 0);

    // Reset during a run after a mismatch was already flagged.
    set_fault(5, 8'h01, 8'h00);
    abort_run(50);
    // Reset on the edge that registers a failing read: the compare is dropped.
    set_fault(15, 8'h01, 8'h00);
    abort_run(48);

    set_fault(-1, '0, '0);
    full_run(1'b0);
    check("run after abort fail", int'(bus.fail), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
